demux_deser: RTL and testbench

Serial-to-parallel receive end for the 8-to-1 multiplexer path. It samples a one-bit stream `y`, produced by a mux whose select walks 0..7, and writes each bit into output position `o[s]`. Once all eight positions of a frame are captured, it presents the word on `o` and pulses `valid`. Its `s` output can drive the transmitting mux's select directly, closing a loopback in the lab designs.

---
 rtl/demux_pkg.sv | 9 +
 rtl/demux_deser_sel_counter.sv | 20 ++
 rtl/demux_deser.sv | 71 +++++++
 tb/tb_demux_deser.sv | 111 +++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 8-to-1 demux deserializer.
package demux_pkg;
  localparam int N  = 8;
  localparam int SW = 3;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [N-1:0] O_RST = '0;
endpackage

// File: rtl/demux_deser_sel_counter.sv
// Select counter: clear wins over load-1, which wins over increment.
module sel_counter #(
  parameter int N  = demux_pkg::N,
  parameter int SW = demux_pkg::SW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] s,
  output logic          term
);
  always_ff @(posedge clk) begin
    if (clr)        s <= '0;
    else if (load1) s <= SW'(1);
    else if (inc)   s <= s + SW'(1);
  end

  assign term = (s == SW'(N-1));
endmodule

// File: rtl/demux_deser.sv
// Serial-to-parallel receiver: bit y lands in position s; full word goes to o with a valid pulse.
module demux_deser #(
  parameter int N  = demux_pkg::N,
  parameter int SW = demux_pkg::SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          y,
  input  logic          start,
  input  logic          en,
  output logic [SW-1:0] s,
  output logic [N-1:0]  o,
  output logic          valid,
  output logic          busy
);
  import demux_pkg::*;

  state_t state_q, state_d;
  logic   term, done, shift_wr;
  // The top bit never passes through the shadow; it goes straight into o.
  logic [N-2:0] sh, sh_we;

  sel_counter #(.N(N), .SW(SW)) u_sel (
    .clk   (clk),
    .clr   (rst || done),
    .load1 (start),
    .inc   (shift_wr || done),
    .s     (s),
    .term  (term)
  );

  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    shift_wr = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = SHIFT;
      SHIFT: begin
        if (start) state_d = SHIFT;
        else if (en && term) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (en) shift_wr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_we = '0;
    for (int i = 0; i < N-1; i++)
      sh_we[i] = (start && i == 0) || (shift_wr && s == SW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh      <= '0;
      o       <= N'(O_RST);
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < N-1; i++)
        if (sh_we[i]) sh[i] <= y;
      if (done) o <= {y, sh};
      valid <= done;
    end
  end

  assign busy = (state_q == SHIFT);
endmodule

// File: tb/tb_demux_deser.sv
// Directed bench for demux_deser: framing, gaps, restart, back-to-back, reset, loopback.
module tb_demux_deser;
  logic       clk = 0;
  logic       rst = 0, y = 0, start = 0, en = 0, loop = 0;
  logic [7:0] lb_i = 8'h00;
  logic       y_drv;
  logic [2:0] s;
  logic [7:0] o;
  logic       valid, busy;
  int         total = 0, bad = 0;
  logic [7:0] prev_o = 8'h00;

  always #5 clk = ~clk;

  assign y_drv = loop ? lb_i[s] : y;

  demux_deser dut (
    .clk(clk), .rst(rst), .y(y_drv), .start(start), .en(en),
    .s(s), .o(o), .valid(valid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic e, input logic yi);
    start = st; en = e; y = yi;
    @(posedge clk); #1;
    start = 0; en = 0; y = 0;
  endtask

  // Full frame; start is paired with en=1 to show en is ignored/overridden then.
  task automatic send(input logic [7:0] val, input int gap_at, input int gaplen);
    cyc(1, 1, val[0]);
    chk("start_s", 32'(s), 1); chk("start_busy", 32'(busy), 1);
    chk("start_valid", 32'(valid), 0); chk("start_o", 32'(o), 32'(prev_o));
    for (int k = 1; k < 8; k++) begin
      if (k == gap_at)
        for (int g = 0; g < gaplen; g++) begin
          cyc(0, 0, ~val[k]);
          chk("gap_s", 32'(s), 32'(k)); chk("gap_busy", 32'(busy), 1);
          chk("gap_valid", 32'(valid), 0);
        end
      cyc(0, 1, val[k]);
      if (k < 7) begin
        chk("bit_s", 32'(s), 32'(k + 1)); chk("bit_valid", 32'(valid), 0);
        chk("bit_busy", 32'(busy), 1); chk("bit_o_hold", 32'(o), 32'(prev_o));
      end else begin
        chk("end_valid", 32'(valid), 1); chk("end_o", 32'(o), 32'(val));
        chk("end_s", 32'(s), 0); chk("end_busy", 32'(busy), 0);
        prev_o = val;
      end
    end
  endtask

  initial begin
    rst = 1; cyc(0, 0, 0); cyc(0, 0, 0);
    chk("rst_o", 32'(o), 0); chk("rst_s", 32'(s), 0);
    chk("rst_busy", 32'(busy), 0); chk("rst_valid", 32'(valid), 0);
    rst = 0;

    // en alone in IDLE does nothing
    cyc(0, 1, 1);
    chk("idle_en_busy", 32'(busy), 0); chk("idle_en_s", 32'(s), 0);

    send(8'b1011_0101, 0, 0);
    cyc(0, 0, 0);
    chk("valid_one_cycle", 32'(valid), 0); chk("o_held", 32'(o), 32'hB5);

    // Reuse 0xB5 with a 3-cycle gap before bit 4; o stays B5 throughout
    send(8'b1011_0101, 4, 3);

    // Back-to-back: second start lands in the valid cycle of A5
    send(8'hA5, 0, 0);
    send(8'h3C, 0, 0);
    chk("b2b_prev_o", 32'(prev_o), 32'h3C);

    // Restart: 4 bits of FF, then a fresh 00 frame aborts it
    cyc(1, 0, 1); cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
    chk("partial_s", 32'(s), 4); chk("partial_o", 32'(o), 32'h3C);
    chk("partial_valid", 32'(valid), 0);
    send(8'h00, 0, 0);

    // Mid-frame reset after 5 bits
    cyc(1, 0, 1); cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 0);
    chk("pre_rst_s", 32'(s), 5);
    send(8'h5A, 0, 0);
    cyc(1, 0, 1); cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
    rst = 1; cyc(0, 1, 1); rst = 0;
    chk("mrst_o", 32'(o), 0); chk("mrst_s", 32'(s), 0);
    chk("mrst_busy", 32'(busy), 0); chk("mrst_valid", 32'(valid), 0);
    prev_o = 8'h00;
    cyc(0, 1, 1);
    chk("post_rst_busy", 32'(busy), 0);
    send(8'h81, 0, 0);

    // Loopback: y is lb_i[s] through a combinational mux
    loop = 1; lb_i = 8'h5A;
    cyc(1, 0, 0);
    for (int k = 1; k < 8; k++) cyc(0, 1, 0);
    chk("loop_valid", 32'(valid), 1); chk("loop_o", 32'(o), 32'h5A);
    loop = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
